// File: rtl/viterbi_decoder.sv
// Hard-decision rate-1/2 Viterbi decoder, K=3 or K=4 selectable at reset.
// Register-exchange survivors: one ACS step and one decoded bit per accepted symbol.
module viterbi_decoder #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       choose_constraint_length,
  input  logic [1:0] encoded_in,
  input  logic       in_valid,
  output logic       decoded_bit,
  output logic       out_valid
);

  localparam int NS = 8;
  localparam int CNT_W = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W-1:0]  PM_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TB_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TB_DEPTH - 1);

  logic                k4;
  logic [PM_W-1:0]     pm       [NS];
  logic [TB_DEPTH-1:0] surv     [NS];
  logic [CNT_W-1:0]    cnt;

  logic [PM_W-1:0]     acs_pm   [NS];
  logic [TB_DEPTH-1:0] acs_surv [NS];
  logic                act_v    [NS];
  logic [PM_W-1:0]     min_pm;
  logic [2:0]          best;

  // Expected {G0,G1} parity for input u leaving predecessor state s.
  function automatic logic [1:0] branch_sym(input logic k4m, input logic u, input logic [2:0] s);
    if (k4m) return {u ^ s[2] ^ s[1] ^ s[0], u ^ s[2] ^ s[0]};
    else     return {u ^ s[1] ^ s[0], u ^ s[0]};
  endfunction

  function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
    return {1'b0, a[1] ^ b[1]} + {1'b0, a[0] ^ b[0]};
  endfunction

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
    logic [PM_W:0] s;
    s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
    return s[PM_W] ? PM_MAX : s[PM_W-1:0];
  endfunction

  for (genvar g = 0; g < NS; g++) begin : g_acs
    localparam logic [2:0] S = 3'(g);
    logic [2:0]      p0, p1;
    logic            u, sel;
    logic [PM_W-1:0] c0, c1;

    // Predecessors share the state's low bits shifted up; u is the newest bit of S.
    assign p0 = k4 ? {S[1:0], 1'b0} : {1'b0, S[0], 1'b0};
    assign p1 = p0 | 3'd1;
    assign u  = k4 ? S[2] : S[1];
    assign c0 = sat_add(pm[p0], hamming(encoded_in, branch_sym(k4, u, p0)));
    assign c1 = sat_add(pm[p1], hamming(encoded_in, branch_sym(k4, u, p1)));
    assign sel = (c1 < c0);
    assign act_v[g]    = k4 | ~S[2];
    assign acs_pm[g]   = act_v[g] ? (sel ? c1 : c0) : PM_MAX;
    assign acs_surv[g] = act_v[g] ? {surv[sel ? p1 : p0][TB_DEPTH-2:0], u} : surv[g];
  end

  // Strict compare keeps the lowest-index state on ties.
  always_comb begin
    min_pm = PM_MAX;
    best   = 3'd0;
    for (int i = 0; i < NS; i++) begin
      if (act_v[i] && (acs_pm[i] < min_pm)) begin
        min_pm = acs_pm[i];
        best   = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k4          <= choose_constraint_length;
      cnt         <= '0;
      decoded_bit <= 1'b0;
      out_valid   <= 1'b0;
      for (int i = 0; i < NS; i++) begin
        pm[i]   <= (i == 0) ? '0 : PM_MAX;
        surv[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        for (int i = 0; i < NS; i++) begin
          pm[i]   <= act_v[i] ? (acs_pm[i] - min_pm) : PM_MAX;
          surv[i] <= acs_surv[i];
        end
        if (cnt < CNT_FULL) cnt <= cnt + 1'b1;
        if (cnt >= CNT_LAST) begin
          out_valid   <= 1'b1;
          decoded_bit <= acs_surv[best][TB_DEPTH-1];
        end
      end
    end
  end

endmodule
